// File: rtl/carry_output_stage.sv
`default_nettype none
// =============================================================================
// Module      : carry_output_stage
// Description : Configurable per-lane output muxing/registering for a carry
//               chain, plus carry-out. Optional per-lane init values and a
//               synchronous set/reset input are built in when
//               CARRY_OUTPUT_STAGE_INIT_EN is defined.
// Revision    : 1.0
// =============================================================================
module carry_output_stage #(
  parameter int INPUTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_in,
  output logic              cfg_out,
  output logic              cfg_done,
  input  logic              ce,
  input  logic [INPUTS-1:0] lut_out,
  input  logic [INPUTS-1:0] S,
  input  logic              Ci,
`ifdef CARRY_OUTPUT_STAGE_INIT_EN
  input  logic              sr,
`endif
  output logic [INPUTS-1:0] out,
  output logic              Co
);

`ifdef CARRY_OUTPUT_STAGE_INIT_EN
  localparam int CFG_W = 3*INPUTS + 1;
`else
  localparam int CFG_W = 2*INPUTS + 1;
`endif
  localparam int              CNT_W      = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CFG_W);

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    SHIFT  = 2'd1,
    CONF   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-1:0]   chain_q, chain_d;
  logic [INPUTS-1:0]  lane_q, lane_d;
  logic               co_q, co_d;

  logic [INPUTS-1:0]  w_sel_sum;
  logic [INPUTS-1:0]  w_reg_en;
  logic               w_co_reg;
  logic [INPUTS-1:0]  w_lane_src;
  logic               w_conf;

  assign w_sel_sum  = chain_q[INPUTS-1:0];
  assign w_reg_en   = chain_q[2*INPUTS-1:INPUTS];
  assign w_co_reg   = chain_q[2*INPUTS];
  assign w_lane_src = (w_sel_sum & S) | (~w_sel_sum & lut_out);
  assign w_conf     = (state_q == CONF);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    lane_d  = lane_q;
    co_d    = co_q;

    if (cfg_en) begin
      chain_d = {chain_q[CFG_W-2:0], cfg_in};
    end

    case (state_q)
      UNCONF: begin
        if (cfg_en) begin
          state_d = SHIFT;
          cnt_d   = C_CNT_ONE;
        end
      end
      SHIFT: begin
        if (cfg_en) begin
          cnt_d = cnt_q + C_CNT_ONE;
          if (cnt_q + C_CNT_ONE == C_CNT_LAST) begin
            state_d = CONF;
          end
        end
      end
      CONF: begin
        if (cfg_en) begin
          state_d = SHIFT;
          cnt_d   = C_CNT_ONE;
        end
      end
      default: begin
        state_d = UNCONF;
        cnt_d   = '0;
      end
    endcase

    // Any cycle outside CONF, or leaving it, parks the flops; entry to CONF seeds them.
    if (!w_conf || cfg_en) begin
      lane_d = '0;
      co_d   = 1'b0;
`ifdef CARRY_OUTPUT_STAGE_INIT_EN
      if (state_d == CONF) begin
        lane_d = chain_d[3*INPUTS:2*INPUTS+1];
      end
`endif
    end
`ifdef CARRY_OUTPUT_STAGE_INIT_EN
    else if (sr) begin
      lane_d = chain_q[3*INPUTS:2*INPUTS+1];
      co_d   = 1'b0;
    end
`endif
    else if (ce) begin
      lane_d = w_lane_src;
      co_d   = Ci;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNCONF;
      cnt_q   <= '0;
      chain_q <= '0;
      lane_q  <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      lane_q  <= lane_d;
      co_q    <= co_d;
    end
  end

  assign cfg_out  = chain_q[CFG_W-1];
  assign cfg_done = w_conf;
  assign out      = w_conf ? ((w_reg_en & lane_q) | (~w_reg_en & w_lane_src)) : '0;
  assign Co       = w_conf ? (w_co_reg ? co_q : Ci) : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_carry_output_stage.sv
`default_nettype none
// =============================================================================
// Module      : tb_carry_output_stage
// Description : Self-checking bench for carry_output_stage (INPUTS=4, no init).
// Revision    : 1.0
// =============================================================================
module tb_carry_output_stage;

  logic       clk = 1'b0;
  logic       rst, cfg_en, cfg_in, ce, Ci;
  logic [3:0] lut_out, S;
  logic       cfg_out, cfg_done, Co;
  logic [3:0] out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the 9 most recently shifted config bits, oldest first.
  bit       m_bits[$];
  int       m_nbits;
  bit       m_conf;
  bit [3:0] m_q;
  bit       m_qc;

  carry_output_stage #(.INPUTS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_en  (cfg_en),
    .cfg_in  (cfg_in),
    .cfg_out (cfg_out),
    .cfg_done(cfg_done),
    .ce      (ce),
    .lut_out (lut_out),
    .S       (S),
    .Ci      (Ci),
    .out     (out),
    .Co      (Co)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] m_word();
    logic [8:0] w;
    for (int i = 0; i < 9; i++) w[i] = m_bits[8-i];
    return w;
  endfunction

  function automatic logic [3:0] m_src();
    logic [8:0] w;
    logic [3:0] d;
    w = m_word();
    for (int i = 0; i < 4; i++) d[i] = w[i] ? S[i] : lut_out[i];
    return d;
  endfunction

  function automatic logic [3:0] exp_out();
    logic [8:0] w;
    logic [3:0] d, o;
    w = m_word();
    d = m_src();
    if (!m_conf) return 4'b0000;
    for (int i = 0; i < 4; i++) o[i] = w[4+i] ? m_q[i] : d[i];
    return o;
  endfunction

  function automatic logic exp_co();
    logic [8:0] w;
    w = m_word();
    if (!m_conf) return 1'b0;
    return w[8] ? m_qc : Ci;
  endfunction

  // Advance model with the inputs present at the coming edge, then cross it.
  task automatic cycle();
    if (rst) begin
      m_bits.delete();
      repeat (9) m_bits.push_back(1'b0);
      m_nbits = 0; m_conf = 0; m_q = '0; m_qc = 0;
    end else if (cfg_en) begin
      m_bits.push_back(cfg_in);
      void'(m_bits.pop_front());
      if (m_conf) begin m_conf = 0; m_nbits = 1; end
      else m_nbits++;
      if (m_nbits == 9) m_conf = 1;
      m_q = '0; m_qc = 0;
    end else if (m_conf && ce) begin
      m_q  = m_src();
      m_qc = Ci;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [8:0] w);
    for (int k = 8; k >= 0; k--) begin
      cfg_en = 1'b1; cfg_in = w[k];
      cycle();
    end
    cfg_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_en = 1'b1; cfg_in = 1'b1; ce = 1'b1; Ci = 1'b1;
    S = 4'hF; lut_out = 4'hF;
    cycle();
    rst = 1'b0; cfg_en = 1'b0;
    #1;
    n_checks++; if (out !== 4'b0000) begin n_errors++; $display("FAIL reset_out got %b want 0000", out); end
    n_checks++; if (Co !== 1'b0) begin n_errors++; $display("FAIL reset_co got %b want 0", Co); end
    n_checks++; if (cfg_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", cfg_done); end
    n_checks++; if (cfg_out !== 1'b0) begin n_errors++; $display("FAIL reset_cfg_out got %b want 0", cfg_out); end
  endtask

  task automatic test_full_config();
    logic [8:0] w;
    w = 9'b0_0000_1111;
    ce = 1'b0;
    for (int k = 8; k >= 0; k--) begin
      cfg_en = 1'b1; cfg_in = w[k];
      #1;
      n_checks++; if (cfg_done !== 1'b0) begin n_errors++; $display("FAIL full_done_early bit %0d got %b want 0", k, cfg_done); end
      cycle();
    end
    cfg_en = 1'b0; S = 4'b1010; Ci = 1'b1; lut_out = 4'($urandom);
    #1;
    n_checks++; if (cfg_done !== 1'b1) begin n_errors++; $display("FAIL full_done got %b want 1", cfg_done); end
    n_checks++; if (out !== 4'b1010) begin n_errors++; $display("FAIL full_out got %b want 1010", out); end
    n_checks++; if (Co !== 1'b1) begin n_errors++; $display("FAIL full_co got %b want 1", Co); end
    n_checks++; if (out !== exp_out()) begin n_errors++; $display("FAIL full_out_model got %b want %b", out, exp_out()); end
  endtask

  task automatic test_registered();
    load_word(9'b0_1111_0000);
    lut_out = 4'b0110; S = 4'b1001; ce = 1'b1; Ci = 1'b0;
    #1;
    n_checks++; if (out !== 4'b0000) begin n_errors++; $display("FAIL reg_entry got %b want 0000", out); end
    cycle();
    ce = 1'b0; lut_out = 4'b1001;
    #1;
    n_checks++; if (out !== 4'b0110) begin n_errors++; $display("FAIL reg_latency got %b want 0110", out); end
    n_checks++; if (Co !== 1'b0) begin n_errors++; $display("FAIL reg_co_comb got %b want 0", Co); end
    cycle();
    n_checks++; if (out !== 4'b0110) begin n_errors++; $display("FAIL reg_hold got %b want 0110", out); end
    n_checks++; if (out !== exp_out()) begin n_errors++; $display("FAIL reg_model got %b want %b", out, exp_out()); end
  endtask

  task automatic test_partial_shift();
    rst = 1'b1; cycle(); rst = 1'b0;
    S = 4'hF; lut_out = 4'hF; Ci = 1'b1; ce = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      cfg_en = (p <= 5 || p > 8); cfg_in = 1'($urandom);
      cycle();
      cfg_en = 1'b0;
      #1;
      n_checks++;
      if (cfg_done !== (p == 12)) begin n_errors++; $display("FAIL partial_done step %0d got %b want %b", p, cfg_done, (p == 12)); end
      if (p < 12) begin
        n_checks++;
        if (out !== 4'b0000 || Co !== 1'b0) begin n_errors++; $display("FAIL partial_forced step %0d got out=%b Co=%b want 0", p, out, Co); end
      end
    end
  endtask

  task automatic test_reset_midshift();
    bit rec[9];
    for (int k = 0; k < 6; k++) begin
      cfg_en = 1'b1; cfg_in = 1'($urandom); cycle();
    end
    cfg_en = 1'b0; rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      rec[k] = 1'($urandom);
      cfg_en = 1'b1; cfg_in = rec[k]; cycle();
      cfg_en = 1'b0; #1;
      n_checks++;
      if (cfg_done !== (k == 8)) begin n_errors++; $display("FAIL midrst_done bit %0d got %b want %b", k, cfg_done, (k == 8)); end
    end
    n_checks++; if (cfg_out !== rec[0]) begin n_errors++; $display("FAIL replay_cfg_out got %b want %b", cfg_out, rec[0]); end
    S = 4'hF; lut_out = 4'hF; Ci = 1'b1;
    cfg_en = 1'b1; ce = 1'b1; cfg_in = 1'b0; cycle();
    cfg_en = 1'b0; #1;
    n_checks++; if (cfg_done !== 1'b0) begin n_errors++; $display("FAIL reconf_done got %b want 0", cfg_done); end
    n_checks++; if (out !== 4'b0000 || Co !== 1'b0) begin n_errors++; $display("FAIL reconf_out got out=%b Co=%b want 0", out, Co); end
    n_checks++; if (cfg_out !== rec[1]) begin n_errors++; $display("FAIL replay_cfg_out2 got %b want %b", cfg_out, rec[1]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      cfg_en  = ($urandom_range(0, 5) == 0);
      cfg_in  = 1'($urandom);
      ce      = 1'($urandom);
      Ci      = 1'($urandom);
      S       = 4'($urandom);
      lut_out = 4'($urandom);
      #1;
      n_checks++;
      if (out !== exp_out() || Co !== exp_co() || cfg_done !== m_conf || cfg_out !== m_bits[0]) begin
        n_errors++;
        $display("FAIL random iter %0d got out=%b Co=%b done=%b cfg_out=%b want out=%b Co=%b done=%b cfg_out=%b",
                 n, out, Co, cfg_done, cfg_out, exp_out(), exp_co(), m_conf, m_bits[0]);
      end
      cycle();
    end
  endtask

  initial begin
    repeat (9) m_bits.push_back(1'b0);
    m_nbits = 0; m_conf = 0; m_q = '0; m_qc = 0;
    rst = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; ce = 1'b0; Ci = 1'b0;
    S = '0; lut_out = '0;
    @(posedge clk); #1;
    test_reset();
    test_full_config();
    test_registered();
    test_partial_shift();
    test_reset_midshift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
